press_counter: RTL and testbench
================================

PRESS_COUNTER -- requirements
Module: press_counter

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 120000, meaning the number of consecutive stable clk cycles that qualifies a press or release (10 ms at 12 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 6000000, meaning the number of clk cycles held in PRESSED that qualifies a long press (0.5 s at 12 MHz).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, 12 MHz board oscillator.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port btn_n, input, 1 bit: raw push button, active-low, asynchronous to clk, bouncing.
REQ-006 SHALL have port led, output, 4 bits: registered binary press count.
REQ-007 SHALL have port press_pulse, output, 1 bit: one-cycle strobe per qualified press.
REQ-008 SHALL have port long_pulse, output, 1 bit: one-cycle strobe per qualified long press.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass btn_n through a 2-flop synchronizer; btn_s = ~(second flop), 1 = pressed.
REQ-011 SHALL implement FSM states IDLE, DEB_PRESS, PRESSED and DEB_RELEASE, with one debounce counter (width clog2(DEB_CYCLES)) and one hold counter (width clog2(LONG_CYCLES)).
REQ-012 IDLE: btn_s=1 SHALL move the FSM to DEB_PRESS with the debounce counter set to 0.
REQ-013 DEB_PRESS: btn_s=0 SHALL return the FSM to IDLE with no output effect; otherwise the debounce counter SHALL increment.
REQ-014 DEB_PRESS: on the cycle the debounce counter equals DEB_CYCLES-1 with btn_s=1, the next edge SHALL go to PRESSED, set press_pulse=1 for exactly one cycle, increment led modulo 16 (15->0), and clear the hold counter.
REQ-015 Press latency: when btn_n is stable low from clk edge k, press_pulse SHALL be high in the cycle following edge k+2+DEB_CYCLES.
REQ-016 PRESSED: btn_s=0 SHALL move the FSM to DEB_RELEASE with the debounce counter set to 0.
REQ-017 DEB_RELEASE: btn_s=1 SHALL return the FSM to PRESSED with the hold counter preserved; counting as in REQ-013/014 reaching DEB_CYCLES-1 SHALL move the FSM to IDLE with no pulse.
REQ-018 A bounce SHALL NOT produce more than one press_pulse per qualified press.
REQ-019 led SHALL change only on press_pulse (+1) or long_pulse (clear); a simultaneous event is impossible by construction and SHALL be asserted never to occur.
REQ-020 press_pulse and long_pulse SHALL be registered outputs.

Reset
REQ-021 rst=1 SHALL, asynchronously, set state=IDLE, both counters=0, led=0, press_pulse=0, long_pulse=0, busy=0, and synchronizer flops=1 (released).
REQ-022 rst asserted mid-press SHALL abort without any pulse; after release, a still-held button SHALL be qualified afresh from IDLE (2+DEB_CYCLES cycles).

Configuration
REQ-023 With macro PRESS_COUNTER_LONG_CLR_EN defined: in PRESSED the hold counter SHALL increment (saturating); on reaching LONG_CYCLES-1 the next edge SHALL pulse long_pulse once and set led=0; at most one long_pulse SHALL occur per qualified press.
REQ-024 Without PRESS_COUNTER_LONG_CLR_EN: the hold counter SHALL be absent, long_pulse SHALL be tied to 0, and PRESSED SHALL only wait for release.

Structure
REQ-025 Package press_counter_pkg SHALL hold the state encoding (2-bit localparams) and the default DEB_CYCLES/LONG_CYCLES constants.
REQ-026 The synchronizer SHALL be sub-module btn_sync (2-flop, reset value 1).

Verification (DEB_CYCLES=4, LONG_CYCLES=20)
REQ-027 Clean press: btn_n low for 30 cycles, then high -> one press_pulse 7 cycles after the falling edge, led 0->1, busy back to 0 after release debounce.
REQ-028 Bounce: btn_n toggled low/high every 2 cycles for 20 cycles, then steady low -> exactly one press_pulse, led=1.
REQ-029 Wrap: 16 clean presses -> led reads 1..15, then 0; one press_pulse per press.
REQ-030 Long press (macro on): led=5, hold btn_n low for 60 cycles -> press_pulse (led=6), then one long_pulse 20 cycles later with led=0, and no second long_pulse before release.
REQ-031 Reset mid-operation: rst pulsed in DEB_PRESS and again in PRESSED -> led=0, no pulses, state IDLE, busy=0; a still-held button is requalified.
REQ-032 Macro off: the REQ-030 stimulus -> led=6, long_pulse stays 0 throughout.

Source files
------------

// File: rtl/press_counter_pkg.sv
// press_counter_pkg: shared constants and state encoding for the press counter.
// Holds the default debounce/long-press cycle counts (12 MHz board clock) and
// the 2-bit FSM encoding used by press_counter.
package press_counter_pkg;

  // 10 ms and 0.5 s at 12 MHz
  localparam int DEB_CYCLES_DEFAULT  = 120000;
  localparam int LONG_CYCLES_DEFAULT = 6000000;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED     = 2'd2;
  localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE        = ST_IDLE,
    DEB_PRESS   = ST_DEB_PRESS,
    PRESSED     = ST_PRESSED,
    DEB_RELEASE = ST_DEB_RELEASE
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchronizer for the raw, active-low push button.
// Both flops reset to 1 (button released); btn_s is the active-high
// "pressed" level in the clk domain.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_s
);

  logic [1:0] sync_q;

  // Shift the asynchronous button level through two flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  assign btn_s = ~sync_q[1];

endmodule

// File: rtl/press_counter.sv
// press_counter: debounced push-button press counter.
// A bouncing active-low button is synchronized, debounced by a four-state
// FSM, and each qualified press bumps the 4-bit led count (mod 16) with a
// one-cycle press_pulse. Optional feature, macro PRESS_COUNTER_LONG_CLR_EN:
// holding the button LONG_CYCLES cycles emits one long_pulse and clears led.
module press_counter
  import press_counter_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic [3:0] led,
  output logic       press_pulse,
  output logic       long_pulse,
  output logic       busy
);

  localparam int             DW       = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
    $error("press_counter: DEB_CYCLES and LONG_CYCLES must be at least 2");
  end

  logic          btn_s;
  state_t        state;
  logic [DW-1:0] deb_cnt;

`ifdef PRESS_COUNTER_LONG_CLR_EN
  localparam int            HW        = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          long_done;   // long_pulse already issued for this press
`else
  assign long_pulse = 1'b0;
`endif

  btn_sync u_btn_sync (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .btn_s (btn_s)
  );

  // Debounce FSM with registered led count, strobes and busy flag
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values of state/counters, exactly like the hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      led         <= '0;
      press_pulse <= 1'b0;
      busy        <= 1'b0;
`ifdef PRESS_COUNTER_LONG_CLR_EN
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      long_pulse  <= 1'b0;
`endif
    end else begin
      press_pulse <= 1'b0;
`ifdef PRESS_COUNTER_LONG_CLR_EN
      long_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (btn_s) begin
            state   <= DEB_PRESS;
            deb_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        DEB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            led         <= led + 4'd1;
`ifdef PRESS_COUNTER_LONG_CLR_EN
            hold_cnt    <= '0;
            long_done   <= 1'b0;
`endif
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        PRESSED: begin
          if (!btn_s) begin
            state   <= DEB_RELEASE;
            deb_cnt <= '0;
          end
`ifdef PRESS_COUNTER_LONG_CLR_EN
          else if (hold_cnt == HOLD_LAST) begin
            // Counter saturates here; long_done limits it to one strobe
            if (!long_done) begin
              long_pulse <= 1'b1;
              led        <= '0;
              long_done  <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end

        DEB_RELEASE: begin
          // A bounce back to pressed resumes the hold count where it was
          if (btn_s) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Press and long strobes come from different states, so never coincide
  a_no_simultaneous_strobes : assert property (
    @(posedge clk) disable iff (rst) !(press_pulse && long_pulse)
  );

endmodule

// File: tb/tb_press_counter.sv
// tb_press_counter: directed stimulus with a scoreboard for press_counter
// (DEB_CYCLES=4, LONG_CYCLES=20). Stimulus pushes the expected strobe (kind,
// led value, cycle) into a queue; a negedge monitor pops and compares every
// strobe the DUT raises. Compile with PRESS_COUNTER_LONG_CLR_EN to match the
// RTL build.
module tb_press_counter;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  // btn_n driven just after edge c -> press_pulse visible after edge c+2+DEB+1
  localparam int PRESS_LAT = DEB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_n;
  logic [3:0] led;
  logic       press_pulse;
  logic       long_pulse;
  logic       busy;

  press_counter #(
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .led         (led),
    .press_pulse (press_pulse),
    .long_pulse  (long_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_long;
    logic [3:0] led;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected entry
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (press_pulse || long_pulse)) begin
      check("single_strobe", 32'(press_pulse & long_pulse), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, press_pulse, long_pulse}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 32'(long_pulse), 32'(e.is_long));
        check("strobe_led", 32'(led), 32'(e.led));
        check("strobe_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_press(input logic [3:0] exp_led);
    exp_q.push_back('{1'b0, exp_led, cyc + PRESS_LAT});
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    btn_n = 1'b1;
    tick(2);
    check("reset_led", 32'(led), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_press_pulse", 32'(press_pulse), 32'd0);
    check("reset_long_pulse", 32'(long_pulse), 32'd0);
    rst = 1'b0;
    tick(2);
  endtask

  // Clean press held for hold cycles, then release and wait out debounce
  task automatic press(input int hold, input logic [3:0] exp_led);
    btn_n = 1'b0;
    expect_press(exp_led);
    tick(hold);
    btn_n = 1'b1;
    tick(10);
    check("busy_after_release", 32'(busy), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    btn_n = 1'b1;

    // Clean press
    do_reset();
    press(30, 4'd1);
    check("clean_led", 32'(led), 32'd1);

    // Bouncing button then steady low
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    btn_n = 1'b0;
    expect_press(4'd1);
    tick(20);
    btn_n = 1'b1;
    tick(10);
    check("bounce_led", 32'(led), 32'd1);
    check("bounce_busy", 32'(busy), 32'd0);

    // Sixteen presses wrap the count back to zero
    do_reset();
    for (int i = 1; i <= 16; i++) press(12, 4'(i));
    check("wrap_led", 32'(led), 32'd0);

    // Reset in DEB_PRESS, then again in PRESSED, button held throughout
    do_reset();
    btn_n = 1'b0;
    tick(4);
    check("deb_press_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst1_led", 32'(led), 32'd0);
    check("rst1_busy", 32'(busy), 32'd0);
    #1;
    rst = 1'b0;
    expect_press(4'd1);
    tick(9);
    check("requal1_busy", 32'(busy), 32'd1);
    check("requal1_led", 32'(led), 32'd1);
    rst = 1'b1;
    #1;
    check("rst2_led", 32'(led), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_press_pulse", 32'(press_pulse), 32'd0);
    #1;
    rst = 1'b0;
    expect_press(4'd1);
    tick(12);
    btn_n = 1'b1;
    tick(10);
    check("requal2_led", 32'(led), 32'd1);
    check("requal2_busy", 32'(busy), 32'd0);

    // Long press from led=5
    do_reset();
    for (int i = 1; i <= 5; i++) press(12, 4'(i));
    btn_n = 1'b0;
    expect_press(4'd6);
`ifdef PRESS_COUNTER_LONG_CLR_EN
    exp_q.push_back('{1'b1, 4'd0, cyc + PRESS_LAT + LONG});
`endif
    tick(60);
    btn_n = 1'b1;
    tick(10);
`ifdef PRESS_COUNTER_LONG_CLR_EN
    check("long_led", 32'(led), 32'd0);
`else
    check("long_led", 32'(led), 32'd6);
`endif
    check("long_busy", 32'(busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
